// File: rtl/prefetch_pkg.sv
// rtl/prefetch_pkg.sv - shared widths, FSM state encoding and buffer entry layout for prefetch_responder
package prefetch_pkg;

    localparam int ADDR_W_DEFAULT = 16;
    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic                      valid;
        logic [ADDR_W_DEFAULT-1:0] addr;
        logic [DATA_W_DEFAULT-1:0] data;
    } buf_entry_t;

endpackage

// File: rtl/prefetch_req_fifo.sv
// rtl/prefetch_req_fifo.sv - prefetch request FIFO; pushes while full are dropped, count is registered
module prefetch_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Fullness comes from the registered count, so a same-cycle pop cannot make room for a push.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/prefetch_responder.sv
// rtl/prefetch_responder.sv - queues prefetch strobes, issues single reads, fills a FIFO-replaced CAM buffer
// Optional statistics counters built when PREFETCH_RESP_STATS_EN is defined.
module prefetch_responder
    import prefetch_pkg::*;
#(
    parameter int QDEPTH      = 4,
    parameter int BUF_ENTRIES = 8,
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int DATA_W      = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              submitMemRequest,
    input  logic [ADDR_W-1:0] requestAddress,
    output logic              memReadEn,
    output logic [ADDR_W-1:0] memReadAddr,
    input  logic              memReadValid,
    input  logic [DATA_W-1:0] memReadData,
    input  logic              demandValid,
    input  logic [ADDR_W-1:0] demandAddr,
    output logic              demandHit,
    output logic [DATA_W-1:0] demandData,
    output logic              queueFull,
    output logic [7:0]        dropCount,
    output logic [7:0]        hitCount
);

    localparam int PW = $clog2(BUF_ENTRIES);
    localparam int CW = $clog2(QDEPTH) + 1;

    state_t            state;
    state_t            next_state;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [CW-1:0]     q_count;
    logic              q_full;
    logic              q_empty;
    logic [ADDR_W-1:0] req_addr;

    logic              buf_valid [BUF_ENTRIES];
    logic [ADDR_W-1:0] buf_addr  [BUF_ENTRIES];
    logic [DATA_W-1:0] buf_data  [BUF_ENTRIES];
    logic [PW-1:0]     buf_ptr;

    logic              head_match;
    logic              probe_hit;
    logic [DATA_W-1:0] probe_data;
    logic              fill;
    logic              dup_drop;
    logic              drop_full;

    prefetch_req_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (ADDR_W)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (submitMemRequest),
        .din   (requestAddress),
        .pop   (pop),
        .dout  (head_addr),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign queueFull = q_full;
    assign drop_full = submitMemRequest && (q_count == CW'(QDEPTH));

    // Reverse scan so the lowest matching index is the one left standing.
    always_comb begin
        head_match = 1'b0;
        probe_hit  = 1'b0;
        probe_data = '0;
        for (int i = BUF_ENTRIES - 1; i >= 0; i--) begin
            if (buf_valid[i] && (buf_addr[i] == head_addr)) head_match = 1'b1;
            if (buf_valid[i] && (buf_addr[i] == demandAddr)) begin
                probe_hit  = 1'b1;
                probe_data = buf_data[i];
            end
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!q_empty) begin
                    pop = 1'b1;
                    if (!head_match) next_state = ISSUE;
                end
            end
            ISSUE:   next_state = WAIT;
            WAIT:    if (memReadValid) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign fill     = (state == WAIT) && memReadValid;
    assign dup_drop = pop && head_match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_addr    <= '0;
            memReadEn   <= 1'b0;
            memReadAddr <= '0;
        end else begin
            state     <= next_state;
            memReadEn <= (state == ISSUE);
            if (pop && !head_match) req_addr <= head_addr;
            if (state == ISSUE) memReadAddr <= req_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_ptr <= '0;
            for (int i = 0; i < BUF_ENTRIES; i++) begin
                buf_valid[i] <= 1'b0;
                buf_addr[i]  <= '0;
                buf_data[i]  <= '0;
            end
        end else if (fill) begin
            buf_valid[buf_ptr] <= 1'b1;
            buf_addr[buf_ptr]  <= req_addr;
            buf_data[buf_ptr]  <= memReadData;
            buf_ptr            <= buf_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            demandHit  <= 1'b0;
            demandData <= '0;
        end else begin
            demandHit  <= demandValid && probe_hit;
            demandData <= (demandValid && probe_hit) ? probe_data : '0;
        end
    end

`ifdef PREFETCH_RESP_STATS_EN
    logic [7:0] drop_cnt;
    logic [7:0] hit_cnt;
    logic [8:0] drop_sum;

    // A full-queue drop and a duplicate discard can land in the same cycle.
    assign drop_sum = {1'b0, drop_cnt} + {8'd0, drop_full} + {8'd0, dup_drop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
            hit_cnt  <= '0;
        end else begin
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            if (demandValid && probe_hit && (hit_cnt != 8'hFF)) hit_cnt <= hit_cnt + 1'b1;
        end
    end

    assign dropCount = drop_cnt;
    assign hitCount  = hit_cnt;
`else
    logic unused_stats;
    assign unused_stats = drop_full ^ dup_drop;
    assign dropCount    = '0;
    assign hitCount     = '0;
`endif

endmodule

// File: tb/tb_prefetch_responder.sv
// tb/tb_prefetch_responder.sv - directed self-checking bench for prefetch_responder
module tb_prefetch_responder;

`ifdef PREFETCH_RESP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        submitMemRequest;
    logic [15:0] requestAddress;
    logic        memReadEn;
    logic [15:0] memReadAddr;
    logic        memReadValid;
    logic [15:0] memReadData;
    logic        demandValid;
    logic [15:0] demandAddr;
    logic        demandHit;
    logic [15:0] demandData;
    logic        queueFull;
    logic [7:0]  dropCount;
    logic [7:0]  hitCount;

    int checks   = 0;
    int failures = 0;
    int exp_drop = 0;
    int exp_hit  = 0;

    always #5 clk = ~clk;

    prefetch_responder dut (
        .clk              (clk),
        .rst              (rst),
        .submitMemRequest (submitMemRequest),
        .requestAddress   (requestAddress),
        .memReadEn        (memReadEn),
        .memReadAddr      (memReadAddr),
        .memReadValid     (memReadValid),
        .memReadData      (memReadData),
        .demandValid      (demandValid),
        .demandAddr       (demandAddr),
        .demandHit        (demandHit),
        .demandData       (demandData),
        .queueFull        (queueFull),
        .dropCount        (dropCount),
        .hitCount         (hitCount)
    );

    task automatic send_req(input logic [15:0] a);
        submitMemRequest = 1'b1;
        requestAddress   = a;
        @(negedge clk);
        submitMemRequest = 1'b0;
    endtask

    task automatic wait_read(input logic [15:0] a);
        int n = 0;
        while (!memReadEn && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (memReadEn !== 1'b1) begin
            failures++;
            $display("FAIL wait_read: memReadEn=%b after 30 cycles, required 1 for addr %h", memReadEn, a);
        end else begin
            checks++;
            if (memReadAddr !== a) begin
                failures++;
                $display("FAIL read_addr: got %h required %h", memReadAddr, a);
            end
        end
    endtask

    task automatic return_data(input logic [15:0] d);
        memReadValid = 1'b1;
        memReadData  = d;
        @(negedge clk);
        memReadValid = 1'b0;
    endtask

    task automatic probe(input logic [15:0] a);
        demandValid = 1'b1;
        demandAddr  = a;
        @(negedge clk);
        demandValid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        submitMemRequest = 1'b0; requestAddress = '0;
        memReadValid = 1'b0; memReadData = '0;
        demandValid = 1'b0; demandAddr = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({memReadEn, memReadAddr, demandHit, demandData, queueFull} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs: en=%b addr=%h hit=%b data=%h full=%b required all 0",
                     memReadEn, memReadAddr, demandHit, demandData, queueFull);
        end
        checks++;
        if ({dropCount, hitCount} !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters: drop=%0d hit=%0d required 0", dropCount, hitCount);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        send_req(16'h0040);
        checks++;
        if (memReadEn !== 1'b0) begin failures++; $display("FAIL single_edge1: memReadEn=%b required 0", memReadEn); end
        @(negedge clk);
        checks++;
        if (memReadEn !== 1'b0) begin failures++; $display("FAIL single_edge2: memReadEn=%b required 0", memReadEn); end
        @(negedge clk);
        checks++;
        if (memReadEn !== 1'b1 || memReadAddr !== 16'h0040) begin
            failures++;
            $display("FAIL single_edge3: en=%b addr=%h required 1 0040", memReadEn, memReadAddr);
        end
        @(negedge clk);
        checks++;
        if (memReadEn !== 1'b0) begin failures++; $display("FAIL single_pulse_width: memReadEn=%b required 0", memReadEn); end
        return_data(16'hBEEF);
        probe(16'h0040);
        exp_hit++;
        checks++;
        if (demandHit !== 1'b1 || demandData !== 16'hBEEF) begin
            failures++;
            $display("FAIL single_probe: hit=%b data=%h required 1 beef", demandHit, demandData);
        end
        checks++;
        if (hitCount !== (STATS ? 8'(exp_hit) : 8'd0)) begin
            failures++;
            $display("FAIL single_hitcount: got %0d required %0d", hitCount, STATS ? exp_hit : 0);
        end
    endtask

    task automatic test_queue_full;
        int seen = 0;
        send_req(16'h000F);
        wait_read(16'h000F);
        for (int i = 0; i < 4; i++) begin
            submitMemRequest = 1'b1;
            requestAddress   = 16'h0010 + 16'(i);
            @(negedge clk);
        end
        checks++;
        if (queueFull !== 1'b1) begin failures++; $display("FAIL full_after_4: queueFull=%b required 1", queueFull); end
        requestAddress = 16'h0014;
        @(negedge clk);
        submitMemRequest = 1'b0;
        exp_drop++;
        checks++;
        if (queueFull !== 1'b1) begin failures++; $display("FAIL full_after_5: queueFull=%b required 1", queueFull); end
        checks++;
        if (dropCount !== (STATS ? 8'(exp_drop) : 8'd0)) begin
            failures++;
            $display("FAIL full_dropcount: got %0d required %0d", dropCount, STATS ? exp_drop : 0);
        end
        return_data(16'h000F ^ 16'h5A5A);
        for (int i = 0; i < 4; i++) begin
            wait_read(16'h0010 + 16'(i));
            return_data((16'h0010 + 16'(i)) ^ 16'h5A5A);
        end
        for (int i = 0; i < 10; i++) begin
            if (memReadEn) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL full_no_0014_read: reads=%0d required 0", seen); end
        checks++;
        if (queueFull !== 1'b0) begin failures++; $display("FAIL full_drained: queueFull=%b required 0", queueFull); end
    endtask

    task automatic test_duplicate;
        int seen = 0;
        send_req(16'h0020);
        wait_read(16'h0020);
        return_data(16'h0020 ^ 16'h5A5A);
        @(negedge clk);
        send_req(16'h0020);
        for (int i = 0; i < 10; i++) begin
            if (memReadEn) seen++;
            @(negedge clk);
        end
        exp_drop++;
        checks++;
        if (seen != 0) begin failures++; $display("FAIL dup_no_read: reads=%0d required 0", seen); end
        checks++;
        if (dropCount !== (STATS ? 8'(exp_drop) : 8'd0)) begin
            failures++;
            $display("FAIL dup_dropcount: got %0d required %0d", dropCount, STATS ? exp_drop : 0);
        end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 9; i++) begin
            send_req(16'h0100 + 16'(i));
            wait_read(16'h0100 + 16'(i));
            return_data((16'h0100 + 16'(i)) ^ 16'h5A5A);
        end
        probe(16'h0100);
        checks++;
        if (demandHit !== 1'b0 || demandData !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_evicted: hit=%b data=%h required 0 0000", demandHit, demandData);
        end
        probe(16'h0108);
        exp_hit++;
        checks++;
        if (demandHit !== 1'b1 || demandData !== 16'h5B52) begin
            failures++;
            $display("FAIL wrap_newest: hit=%b data=%h required 1 5b52", demandHit, demandData);
        end
        probe(16'h0040);
        checks++;
        if (demandHit !== 1'b0) begin failures++; $display("FAIL wrap_oldest_gone: hit=%b required 0", demandHit); end
    endtask

    task automatic test_same_cycle;
        send_req(16'h0030);
        wait_read(16'h0030);
        memReadValid = 1'b1;
        memReadData  = 16'h3333;
        demandValid  = 1'b1;
        demandAddr   = 16'h0030;
        @(negedge clk);
        memReadValid = 1'b0;
        checks++;
        if (demandHit !== 1'b0) begin failures++; $display("FAIL same_cycle_probe: hit=%b required 0", demandHit); end
        @(negedge clk);
        demandValid = 1'b0;
        exp_hit++;
        checks++;
        if (demandHit !== 1'b1 || demandData !== 16'h3333) begin
            failures++;
            $display("FAIL next_cycle_probe: hit=%b data=%h required 1 3333", demandHit, demandData);
        end
        checks++;
        if (hitCount !== (STATS ? 8'(exp_hit) : 8'd0)) begin
            failures++;
            $display("FAIL same_cycle_hitcount: got %0d required %0d", hitCount, STATS ? exp_hit : 0);
        end
    endtask

    task automatic test_reset_mid_wait;
        int seen = 0;
        send_req(16'h0050);
        wait_read(16'h0050);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({dropCount, hitCount, queueFull} !== 17'd0) begin
            failures++;
            $display("FAIL midwait_reset_state: drop=%0d hit=%0d full=%b required 0", dropCount, hitCount, queueFull);
        end
        return_data(16'h5555);
        for (int i = 0; i < 5; i++) begin
            if (memReadEn) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL midwait_no_read: reads=%0d required 0", seen); end
        probe(16'h0050);
        checks++;
        if (demandHit !== 1'b0 || demandData !== 16'h0000) begin
            failures++;
            $display("FAIL midwait_probe: hit=%b data=%h required 0 0000", demandHit, demandData);
        end
        probe(16'h0108);
        checks++;
        if (demandHit !== 1'b0) begin failures++; $display("FAIL midwait_buffer_cleared: hit=%b required 0", demandHit); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_queue_full();
        test_duplicate();
        test_wrap();
        test_same_cycle();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
